// File: rtl/sram_controller.sv
`default_nettype none
// sram_controller: 32-bit load/store over a 16-bit asynchronous SRAM.
// Each access is two halfword beats, a two-cycle settle, then a one-cycle DONE handshake.
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [31:0] DATA_BASE = 32'd1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    WAIT1  = 3'd3,
    WAIT2  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        is_write_q;
  logic [16:0] index_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic [31:0] offset;
  logic        unused_offset;
  logic        request;
  logic        start;
  logic        in_access;
  logic        drive_dq;

  // Byte offset into the data region; only the word index within 256K halfwords matters.
  assign offset        = address - DATA_BASE;
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  assign request   = wr_en | rd_en;
  assign start     = (state_q == IDLE) && request;
  assign in_access = (state_q == ACC_LO) || (state_q == ACC_HI);
  assign drive_dq  = is_write_q && in_access;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (request) state_d = ACC_LO;
      ACC_LO:  state_d = ACC_HI;
      ACC_HI:  state_d = WAIT1;
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        // Store wins when both requests are raised together.
        is_write_q <= wr_en;
        index_q    <= offset[18:2];
        wdata_q    <= writeData;
      end
      if (!is_write_q && (state_q == ACC_LO)) rdata_q[15:0]  <= SRAM_DQ;
      if (!is_write_q && (state_q == ACC_HI)) rdata_q[31:16] <= SRAM_DQ;
    end
  end

  assign SRAM_ADDR = {index_q, (state_q == ACC_HI)};
  assign SRAM_DQ   = drive_dq ? ((state_q == ACC_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  assign SRAM_WE_N = ~drive_dq;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign readData = rdata_q;
  assign ready    = ~request | (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// tb_sram_controller: directed vector table plus hand sequences against a behavioural 256K x 16 SRAM.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] writeData;
  wire  [31:0] readData;
  wire         ready;
  wire  [15:0] SRAM_DQ;
  wire  [17:0] SRAM_ADDR;
  wire         SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives the bus whenever write strobe is inactive, captures while it is active.
  logic [15:0] mem [0:262143];
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  // Starts in IDLE just after a rising edge; returns in IDLE just after a rising edge.
  task automatic run_vec(input vec_t v, input int id);
    wr_en     = v.wr;
    rd_en     = v.rd;
    address   = v.addr;
    writeData = v.wdata;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("v%0d ready c%0d", id, k), 32'(ready), 32'(k == 5));
      if (k == 1) begin
        check($sformatf("v%0d addr lo", id), 32'(SRAM_ADDR), 32'(v.lo));
        check($sformatf("v%0d we_n lo", id), 32'(SRAM_WE_N), 32'(!v.wr));
      end
      if (k == 2) begin
        check($sformatf("v%0d addr hi", id), 32'(SRAM_ADDR), 32'(v.lo | 18'd1));
        check($sformatf("v%0d we_n hi", id), 32'(SRAM_WE_N), 32'(!v.wr));
      end
      if (k == 3) check($sformatf("v%0d we_n wait", id), 32'(SRAM_WE_N), 32'd1);
      if (k == 5) begin
        check($sformatf("v%0d readData", id), readData, v.exp_rd);
        check($sformatf("v%0d strobes", id), 32'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        // Operands are latched by now; disturbing them must not affect this access.
        address   = 32'hFFFF_FFFF;
        writeData = 32'h0000_0000;
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (v.wr) begin
      check($sformatf("v%0d mem lo", id), 32'(mem[v.lo]), 32'(v.wdata[15:0]));
      check($sformatf("v%0d mem hi", id), 32'(mem[v.lo | 18'd1]), 32'(v.wdata[31:16]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              wr    rd    addr          wdata          lo         exp_rd
    vecs[0] = '{1'b1, 1'b0, 32'd1024,     32'hDEADBEEF, 18'h00000, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024,     32'h0,        18'h00000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1036,     32'h12345678, 18'h00006, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1039,     32'h0,        18'h00006, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'd1040,     32'hA5A55A5A, 18'h00008, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd1040,     32'h0,        18'h00008, 32'hA5A55A5A};
    vecs[6] = '{1'b1, 1'b0, 32'd1028,     32'h0BADF00D, 18'h00002, 32'hA5A55A5A};
    vecs[7] = '{1'b0, 1'b1, 32'h00080402, 32'h0,        18'h00000, 32'hDEADBEEF};
    vecs[8] = '{1'b1, 1'b0, 32'h00000000, 32'hCAFEF00D, 18'h3FE00, 32'hDEADBEEF};
    vecs[9] = '{1'b0, 1'b1, 32'h00000000, 32'h0,        18'h3FE00, 32'hCAFEF00D};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; writeData = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset readData", readData, 32'd0);
    check("reset we_n", 32'(SRAM_WE_N), 32'd1);
    check("reset addr", 32'(SRAM_ADDR), 32'd0);
    check("reset ready idle", 32'(ready), 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    check("reset ready with request", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; rd_en = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle ready c%0d", c), 32'(ready), 32'd1);
      check($sformatf("idle we_n c%0d", c), 32'(SRAM_WE_N), 32'd1);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back reads with rd_en held: completions in cycles 5 and 11.
    rd_en = 1'b1; address = 32'd1024;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("b2b ready c%0d", k), 32'(ready), 32'((k == 5) || (k == 11)));
      if (k == 5)  check("b2b readData 1024", readData, 32'hDEADBEEF);
      if (k == 11) check("b2b readData 1028", readData, 32'h0BADF00D);
      @(posedge clk);
      #1;
      if (k == 5) address = 32'd1028;
    end
    rd_en = 1'b0;

    // Reset while a read sits in WAIT1, then restart with the request re-held.
    rd_en = 1'b1; address = 32'd1024;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset readData", readData, 32'hDEADBEEF);
    rst = 1'b1;
    @(negedge clk);
    check("mid-reset ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post-reset readData", readData, 32'd0);
    check("post-reset we_n", 32'(SRAM_WE_N), 32'd1);
    run_vec(vecs[1], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have ports in this order, clock and reset first: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 wr_en  input  1  MEM-stage store request; held high until ready.
REQ-004 rd_en  input  1  MEM-stage load request; held high until ready.
REQ-005 address  input  32  byte address from the ALU result; data region based at 1024.
REQ-006 writeData  input  32  store data (Val_Rm).
REQ-007 readData  output  32  load result toward the MEM/WB register; WB selects it when mem_read=1.
REQ-008 ready  output  1  access complete; low means the pipeline freezes.
REQ-009 SRAM_DQ  inout  16  external SRAM data bus.
REQ-010 SRAM_ADDR  output  18  external SRAM halfword address.
REQ-011 SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM strobes.
REQ-012 SHALL have no parameters; all widths are fixed as listed above.

Function
REQ-013 Address map: offset = address - 1024, computed mod 2^32. Word index = offset[18:2]. Low half at SRAM_ADDR = {index, 0}; high half at {index, 1}. offset[1:0] and offset[31:19] are ignored.
REQ-014 FSM states are IDLE, ACC_LO, ACC_HI, WAIT1, WAIT2 and DONE. Each non-IDLE state lasts exactly one cycle.
REQ-015 IDLE transitions to ACC_LO when (wr_en | rd_en) = 1; otherwise it stays in IDLE.
REQ-016 The fixed sequence is ACC_LO -> ACC_HI -> WAIT1 -> WAIT2 -> DONE -> IDLE.
REQ-017 Operation type is latched on the IDLE->ACC_LO edge. wr_en has priority when wr_en and rd_en are both high. Address and writeData are also latched on this edge.
REQ-018 ready = ~(wr_en | rd_en) | (state == DONE), combinational. A request first seen in IDLE at cycle 0 gives ready=0 in cycles 0-4 and ready=1 in cycle 5.
REQ-019 Write, ACC_LO: SRAM_ADDR = low address, SRAM_DQ driven with writeData[15:0], SRAM_WE_N = 0.
REQ-020 Write, ACC_HI: SRAM_ADDR = high address, SRAM_DQ driven with writeData[31:16], SRAM_WE_N = 0.
REQ-021 Read, ACC_LO and ACC_HI: SRAM_DQ is high-Z and SRAM_WE_N = 1. SRAM_DQ is sampled at the end of ACC_LO into readData[15:0] and at the end of ACC_HI into readData[31:16].
REQ-022 SRAM_DQ SHALL be high-Z in every state except write ACC_LO and write ACC_HI.
REQ-023 Strobe levels: SRAM_CE_N = SRAM_OE_N = SRAM_UB_N = SRAM_LB_N = 0 at all times. SRAM_WE_N = 1 outside write access states.
REQ-024 readData changes only in read ACC_LO/ACC_HI and is held otherwise. The final value is valid from DONE onward.
REQ-025 A write SHALL NOT modify readData.
REQ-026 Deasserting the request mid-sequence SHALL NOT abort the access. The FSM completes to DONE, then returns to IDLE.
REQ-027 Request still high in IDLE (next instruction after unfreeze) starts a new access immediately. There are no idle gap cycles beyond IDLE itself.
REQ-028 Changes to address or writeData after latching SHALL NOT affect the access in progress.

Reset
REQ-029 rst=1 forces state=IDLE, readData=0, latched address/data/op = 0, SRAM_WE_N=1 and SRAM_DQ high-Z on the next edge.
REQ-030 Reset in any state SHALL abort the access within one cycle; a partial write may leave only the low half written.
REQ-031 ready follows REQ-018 during reset: it is 0 whenever a request is held in reset.

Verification
REQ-032 Write/read round trip: wr_en=1, address=1024, writeData=0xDEADBEEF. Required: SRAM[0]=0xBEEF, SRAM[1]=0xDEAD, ready=1 exactly 5 cycles after the request. Then rd_en=1 at the same address. Required: readData=0xDEADBEEF in DONE.
REQ-033 Address mapping: write 0x12345678 at address 1036. Required: SRAM_ADDR=6 in ACC_LO and 7 in ACC_HI; reading address 1039 returns 0x12345678.
REQ-034 No request: wr_en=rd_en=0 for 10 cycles. Required: ready=1 throughout, SRAM_WE_N=1, SRAM_DQ high-Z, state=IDLE.
REQ-035 Simultaneous requests: wr_en=rd_en=1 with writeData=0xA5A5_5A5A. Required: a write is performed and readData is unchanged.
REQ-036 Reset mid-read: rst pulsed in WAIT1. Required: next cycle state=IDLE and readData=0; a re-held rd_en restarts and completes in 5 cycles.
REQ-037 Back-to-back reads at 1024 and 1028 with rd_en held high. Required: ready pulses for one cycle each, in cycles 5 and 11, and each readData is correct.
